// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//
// Run/pause/clear sequencer for the seconds-counter display datapath.
// It debounces two raw pushbuttons into one-cycle press events. A four-state
// FSM (IDLE/RUN/PAUSE/DONE) uses those events to gate a 1 s prescaler. The
// prescaler ticks a mod-(N+1) up counter (stopwatch) or a load-and-count-down
// timer. `count` feeds the bin2bcd -> char_7seg chain unchanged.
//
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   key_run_n  in   1      raw run/pause pushbutton, active-low, async to clk
//   key_clr_n  in   1      raw clear pushbutton, active-low, async to clk
//   mode_down  in   1      0 = stopwatch (up), 1 = timer (down); used in IDLE only
//   load_val   in   WIDTH  timer start value, clamped to N
//   count      out  WIDTH  current counter value
//   state      out  2      IDLE=0, RUN=1, PAUSE=2, DONE=3
//   tick       out  1      one-cycle prescaler pulse, only while in RUN
//   done       out  1      high while in DONE
module count_seq_ctrl #(
  parameter int WIDTH     = 10,
  parameter int N         = 999,
  parameter int COUNT_1S  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_run_n,
  input  logic             key_clr_n,
  input  logic             mode_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             tick,
  output logic             done
);

  localparam int PRESC_W = 26;
  // Debounce counter only ever reaches DB_CYCLES-1.
  localparam int DB_W = $clog2(DB_CYCLES);

  localparam logic [WIDTH-1:0]   MAX_CNT    = WIDTH'(N);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(COUNT_1S - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturate the timer start value to the counter's maximum.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_CNT) ? MAX_CNT : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Key synchronizer + debounce + press-event stage. Bit 0 is run, bit 1 is clear.
  // ---------------------------------------------------------------------------
  logic [1:0]      keys;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];
  logic            run_ev;
  logic            clr_ev;

  assign keys = {key_clr_n, key_run_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      level   <= 2'b11;
      level_d <= 2'b11;
      press   <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync1   <= keys;
      sync2   <= sync1;
      level_d <= level;
      // Event fires one cycle after the debounced level falls; releases are silent.
      press   <= level_d & ~level;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          level[k]  <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  assign run_ev = press[0];
  assign clr_ev = press[1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM, counter and prescaler stage.
  // ---------------------------------------------------------------------------
  state_t             fsm;
  state_t             fsm_next;
  logic [WIDTH-1:0]   count_next;
  logic [WIDTH-1:0]   idle_val;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_next;
  logic               mode_lat;
  logic               mode_next;
  logic               tick_next;

  assign idle_val = mode_down ? clamp_load(load_val) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      count    <= '0;
      presc    <= '0;
      mode_lat <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      fsm      <= fsm_next;
      count    <= count_next;
      presc    <= presc_next;
      mode_lat <= mode_next;
      tick     <= tick_next;
      done     <= (fsm_next == DONE);
    end
  end

  always_comb begin
    fsm_next   = fsm;
    count_next = count;
    mode_next  = mode_lat;
    presc_next = '0;
    tick_next  = 1'b0;

    case (fsm)
      IDLE: begin
        count_next = idle_val;
        mode_next  = mode_down;
        if (run_ev) begin
          // A timer loaded with zero has nothing to count.
          fsm_next = (mode_lat && (count == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        // A run press wins over a coincident tick: the count is frozen as-is.
        if (run_ev) begin
          fsm_next = PAUSE;
        end else if (tick) begin
          if (mode_lat) begin
            count_next = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              fsm_next = DONE;
            end
          end else begin
            count_next = (count == MAX_CNT) ? '0 : count + WIDTH'(1);
          end
        end
      end
      PAUSE: begin
        if (run_ev) begin
          fsm_next = RUN;
        end
      end
      DONE: begin
        if (run_ev) begin
          fsm_next = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase

    // Clear overrides everything and starts the IDLE reload immediately.
    if (clr_ev) begin
      fsm_next   = IDLE;
      count_next = idle_val;
    end

    // The prescaler only advances while the FSM stays in RUN, so a pause or any
    // exit discards the partial second and re-entry restarts from zero.
    if ((fsm == RUN) && (fsm_next == RUN)) begin
      presc_next = (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      tick_next  = (presc == PRESC_LAST);
    end
  end

  assign state = fsm;

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Run/pause/clear sequencer for the seconds-counter display datapath. Debounces two pushbuttons and runs a state machine that gates a 1 s prescaler. It drives a mod-(N+1) up counter (stopwatch) or a load-and-count-down timer. `count` feeds the existing bin2bcd → char_7seg display chain unchanged.

## Interface
- `WIDTH`, 10: counter width; must satisfy 2^WIDTH > N.
- `N`, 999: maximum count value; the up-count wraps from N to 0.
- `COUNT_1S`, 50_000_000: clk cycles per tick; must be ≥ 2; prescaler width 26.
- `DB_CYCLES`, 1_000_000: debounce stability window in clk cycles; must be ≥ 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_run_n`  in  1  raw pushbutton, active-low, asynchronous to clk.
- `key_clr_n`  in  1  raw pushbutton, active-low, asynchronous to clk.
- `mode_down`  in  1  0 = up/stopwatch, 1 = down/timer; sampled only in IDLE.
- `load_val`  in  WIDTH  down-mode start value; values above N are clamped to N.
- `count`  out  WIDTH  current counter value.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `tick`  out  1  one-cycle prescaler pulse; asserted only in RUN.
- `done`  out  1  high while state==DONE.

## Operation
- **Reset values.** count=0, state=IDLE, tick=0, done=0. Prescaler=0, debounce counters=0, debounced levels=1 (released), sync flops=1, latched mode=0.
- **Debounce, per key.**
  - 2-flop synchronizer feeds a comparison against the debounced level.
  - The debounce counter increments while the synced value ≠ debounced level and clears to 0 when they are equal.
  - When the counter is DB_CYCLES-1 and the values still differ, the debounced level takes the synced value and the counter clears.
  - A press event (run_ev / clr_ev) is a registered 1-cycle pulse, asserted the cycle after the debounced level goes 1→0.
  - Releases generate no event.
- **IDLE.**
  - count is loaded every cycle with mode_down ? min(load_val, N) : 0.
  - The latched mode follows mode_down.
  - On run_ev: if the latched mode is down and count==0, go to DONE; otherwise go to RUN.
- **RUN.**
  - The prescaler counts 0..COUNT_1S-1 and wraps.
  - On tick, up mode: count = (count==N) ? 0 : count+1. Up mode never reaches DONE.
  - On tick, down mode: count-1. If the result is 0, go to DONE on the same edge.
  - run_ev → PAUSE.
- **PAUSE.** count holds. run_ev → RUN.
- **DONE.** count holds (0 in down mode). done=1. run_ev → IDLE.
- **Clear.** clr_ev in any state → IDLE. count is reloaded per the IDLE rule starting the next cycle.
- **Prescaler.** Held at 0 in every state except RUN. A pause therefore discards the partial second.
- **Priority within one cycle.**
  - clr_ev beats run_ev.
  - run_ev beats tick: when run_ev and tick coincide in RUN, go to PAUSE and count does not change.
- **Mode changes.** mode_down and load_val changes outside IDLE are ignored.
- **Asynchronous reset mid-operation.** Every register returns immediately to its reset value, with no event generated.

## Timing
- **Key-to-event latency.** An input transition held stable produces the event pulse 2 (sync) + DB_CYCLES + 1 cycles later.
  - Glitches shorter than DB_CYCLES cycles produce no event.
- **State change.** The state changes on the edge after the cycle in which the event pulse is high.
- **First tick.** Let cycle 0 be the first cycle with state==RUN (prescaler=0).
  - tick=1 in cycle COUNT_1S.
  - The updated count is visible in cycle COUNT_1S+1.
  - Later ticks follow every COUNT_1S cycles.
- **After resume.** Resuming from PAUSE restarts the sequence at cycle 0 with the same latency.
- **Outputs.** All outputs are registered; no combinational input→output paths.
- **done.** Rises on the same edge that sets state=DONE.

## Test plan
All scenarios use parameters COUNT_1S=4, DB_CYCLES=3, N=9, WIDTH=4.
- **Reset and debounce.**
  - Stimulus: hold rst_n=0, then release. Press key_run_n (low for 10 cycles).
  - Required: all outputs 0. state becomes RUN exactly 2+3+1+1 cycles after the key falls.
  - Stimulus: a 2-cycle glitch on key_run_n.
  - Required: no state change.
- **Up count and wrap.**
  - Stimulus: mode_down=0, run.
  - Required: count 0→1 visible 5 cycles after RUN entry, then steps every 4 cycles. count goes 9→0 and state stays RUN.
- **Down count to DONE.**
  - Stimulus: mode_down=1, load_val=12, run.
  - Required: count shows 9 (clamped) in IDLE and counts 9..0. done=1 and state=3 on the edge where count becomes 0. A following run press returns to IDLE with count=9.
- **Pause/resume.**
  - Stimulus: press run when count=3, with the press landing on the tick cycle; then press run again.
  - Required: state=PAUSE and count stays 3. After the resume, the next increment comes 5 cycles after RUN re-entry.
- **Clear priority.**
  - Stimulus: in RUN, run and clear events in the same cycle.
  - Required: state=IDLE and count=0 (up mode).
  - Stimulus: down mode with load_val=0, run press.
  - Required: direct IDLE→DONE transition.
- **Reset mid-run.**
  - Stimulus: assert rst_n=0 for 1 cycle while count=5 in RUN.
  - Required: count=0, state=IDLE and tick=0 immediately, with no spurious event after release.
